// File: rtl/div_period_mon_pkg.sv
// Shared types and defaults for the divided-clock period monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } mon_state_e;

    localparam int DEF_WIN       = 87;
    localparam int DEF_PER_MIN   = 8;
    localparam int DEF_PER_MAX   = 9;
    localparam int DEF_EXP_EDGES = 10;
    localparam int DEF_EDGE_TOL  = 1;
    localparam int DEF_LOCK_N    = 4;
    localparam int DEF_CNT_W     = 8;

    // Two maximum periods without a rise means the divider has stopped.
    function automatic int stuck_lim(input int per_max);
        return 2 * per_max;
    endfunction

endpackage

// File: rtl/div_period_mon_if.sv
// Monitor-side bundle: stimulus/control in, measurements and sticky flags out.
interface div_period_mon_if
    import div_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             clk_in;
    logic             mon_en;
    logic             clr_err;
    logic [CNT_W-1:0] period_last;
    logic             period_vld;
    logic [7:0]       edge_cnt_win;
    logic             win_done;
    logic             locked;
    logic             err_period;
    logic             err_count;
    logic             err_stuck;

    modport master (
        output clk_in, mon_en, clr_err,
        input  period_last, period_vld, edge_cnt_win, win_done,
        input  locked, err_period, err_count, err_stuck
    );

    modport slave (
        input  clk_in, mon_en, clr_err,
        output period_last, period_vld, edge_cnt_win, win_done,
        output locked, err_period, err_count, err_stuck
    );
endinterface

// File: rtl/div_period_mon_rise_det.sv
// Rising-edge detector for a signal already in the sys_clk domain.
module rise_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_sig,
    output logic o_rise
);
    logic r_sig_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_sig_d <= 1'b0;
        else            r_sig_d <= i_sig;
    end

    assign o_rise = i_sig & ~r_sig_d;
endmodule

// File: rtl/div_period_mon.sv
// Measures each divided-clock period, counts rises per window and flags
// period, count and stuck errors; lock tracks consecutive legal periods.
module div_period_mon
    import div_mon_pkg::*;
#(
    parameter int WIN       = DEF_WIN,
    parameter int PER_MIN   = DEF_PER_MIN,
    parameter int PER_MAX   = DEF_PER_MAX,
    parameter int EXP_EDGES = DEF_EXP_EDGES,
    parameter int EDGE_TOL  = DEF_EDGE_TOL,
    parameter int LOCK_N    = DEF_LOCK_N,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    div_period_mon_if.slave  mon
);
    localparam int LR_W    = $clog2(LOCK_N + 1);
    localparam int EDGE_HI = EXP_EDGES + EDGE_TOL;
    localparam int EDGE_LO = (EXP_EDGES > EDGE_TOL) ? (EXP_EDGES - EDGE_TOL) : 0;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] STUCK_C = CNT_W'(stuck_lim(PER_MAX));
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] PMIN_C  = CNT_W'(PER_MIN);
    localparam logic [CNT_W-1:0] PMAX_C  = CNT_W'(PER_MAX);
    localparam logic [LR_W-1:0]  LOCK_C  = LR_W'(LOCK_N);
    localparam logic [LR_W-1:0]  LR_ONE  = {{(LR_W-1){1'b0}}, 1'b1};

    mon_state_e       r_state, w_state_nxt;
    logic             w_rise;
    logic             w_start, w_run, w_per_evt, w_stuck, w_win_end;
    logic             w_per_bad, w_cnt_bad;
    logic [CNT_W-1:0] r_period_cnt, r_win_cnt;
    logic [7:0]       r_win_edges, w_edges_inc;
    logic [LR_W-1:0]  r_lock_run, w_lock_nxt;

    logic [CNT_W-1:0] r_period_last;
    logic             r_period_vld;
    logic [7:0]       r_edge_cnt_win;
    logic             r_win_done, r_locked;
    logic             r_err_period, r_err_count, r_err_stuck;

    rise_det u_rise (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_sig     (mon.clk_in),
        .o_rise    (w_rise)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!mon.mon_en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = SYNC;
                SYNC:    if (w_rise)  w_state_nxt = RUN;
                RUN:     if (w_stuck) w_state_nxt = SYNC;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_start = 1'b0;
        w_run   = 1'b0;
        case (r_state)
            SYNC:    w_start = mon.mon_en & w_rise;
            RUN:     w_run   = mon.mon_en;
            default: ;
        endcase
    end

    // A stuck event abandons the window, so it also suppresses win_done.
    assign w_per_evt = w_run & w_rise;
    assign w_stuck   = w_run & ~w_rise & (r_period_cnt == STUCK_C);
    assign w_win_end = w_run & ~w_stuck & (r_win_cnt == WIN_C);

    assign w_edges_inc = (w_rise && r_win_edges != 8'hFF) ? r_win_edges + 8'd1 : r_win_edges;
    assign w_per_bad   = w_per_evt & ((r_period_cnt < PMIN_C) | (r_period_cnt > PMAX_C));
    assign w_cnt_bad   = w_win_end & ((int'(w_edges_inc) > EDGE_HI) | (int'(w_edges_inc) < EDGE_LO));

    always_comb begin
        w_lock_nxt = r_lock_run;
        if (!mon.mon_en || w_stuck || w_per_bad)
            w_lock_nxt = '0;
        else if (w_per_evt && r_lock_run != LOCK_C)
            w_lock_nxt = r_lock_run + LR_ONE;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_period_cnt <= '0;
            r_win_cnt    <= '0;
            r_win_edges  <= '0;
        end else if (w_start) begin
            r_period_cnt <= CNT_ONE;
            r_win_cnt    <= CNT_ONE;
            r_win_edges  <= '0;
        end else if (w_run) begin
            if (w_rise)                      r_period_cnt <= CNT_ONE;
            else if (r_period_cnt != CNT_MAX) r_period_cnt <= r_period_cnt + CNT_ONE;
            if (w_win_end) begin
                r_win_cnt   <= CNT_ONE;
                r_win_edges <= '0;
            end else begin
                r_win_cnt   <= r_win_cnt + CNT_ONE;
                r_win_edges <= w_edges_inc;
            end
        end else begin
            r_period_cnt <= '0;
            r_win_cnt    <= '0;
            r_win_edges  <= '0;
        end
    end

    // Sticky flags: a same-cycle set beats clr_err.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_period_last  <= '0;
            r_period_vld   <= 1'b0;
            r_edge_cnt_win <= '0;
            r_win_done     <= 1'b0;
            r_lock_run     <= '0;
            r_locked       <= 1'b0;
            r_err_period   <= 1'b0;
            r_err_count    <= 1'b0;
            r_err_stuck    <= 1'b0;
        end else begin
            r_period_vld <= w_per_evt;
            if (w_per_evt) r_period_last <= r_period_cnt;
            r_win_done <= w_win_end;
            if (w_win_end) r_edge_cnt_win <= w_edges_inc;
            r_lock_run   <= w_lock_nxt;
            r_locked     <= (w_lock_nxt == LOCK_C);
            r_err_period <= (r_err_period & ~mon.clr_err) | w_per_bad;
            r_err_count  <= (r_err_count  & ~mon.clr_err) | w_cnt_bad;
            r_err_stuck  <= (r_err_stuck  & ~mon.clr_err) | w_stuck;
        end
    end

    assign mon.period_last  = r_period_last;
    assign mon.period_vld   = r_period_vld;
    assign mon.edge_cnt_win = r_edge_cnt_win;
    assign mon.win_done     = r_win_done;
    assign mon.locked       = r_locked;
    assign mon.err_period   = r_err_period;
    assign mon.err_count    = r_err_count;
    assign mon.err_stuck    = r_err_stuck;
endmodule

// File: tb/tb_div_period_mon.sv
// Bench for div_period_mon: segment table plus hand sequences, with period
// and window scoreboards filled from the generated clk_in pattern.
`timescale 1ns/1ps
module tb_div_period_mon;
    localparam int WIN   = 87;
    localparam int STUCK = 18;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    div_period_mon_if #(.CNT_W(8)) mon_if ();

    div_period_mon #(
        .WIN(87), .PER_MIN(8), .PER_MAX(9), .EXP_EDGES(10),
        .EDGE_TOL(1), .LOCK_N(4), .CNT_W(8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mon       (mon_if)
    );

    typedef struct {
        int   per;
        int   reps;
        logic exp_lock;
        logic exp_errp;
        logic exp_errc;
        logic exp_errs;
    } seg_t;

    seg_t tbl [9];

    int   n_chk = 0, n_fail = 0;
    int   q_per [$];
    int   q_win [$];
    int   n_tick = 0, m_state = 0, m_last = 0, m_ws = 0, m_we = 0;
    int   m_lastper = 0, m_lastwin = 0, m_win_tick = -1;
    logic m_prev = 1'b0, m_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one sys_clk cycle of stimulus and advance the expectation model.
    task automatic tick(input logic v, input logic clr);
        logic rise;
        @(posedge sys_clk); #1;
        mon_if.clk_in  = v;
        mon_if.clr_err = clr;
        mon_if.mon_en  = m_en;
        n_tick++;
        rise   = v & ~m_prev;
        m_prev = v;
        if (!m_en) m_state = 0;
        else case (m_state)
            0: m_state = 1;
            1: if (rise) begin
                m_state = 2; m_last = n_tick; m_ws = n_tick; m_we = 0;
            end
            default: begin
                if (rise) begin
                    m_lastper = n_tick - m_last;
                    q_per.push_back(m_lastper);
                    m_last = n_tick;
                    m_we++;
                end else if (n_tick - m_last == STUCK) begin
                    m_state = 1;
                end
                if (m_state == 2 && ((n_tick - m_ws) % WIN) == 0) begin
                    m_lastwin = m_we;
                    q_win.push_back(m_we);
                    m_we = 0;
                    m_win_tick = n_tick;
                end
            end
        endcase
    endtask

    task automatic run_period(input int p, input logic clr_first);
        for (int i = 0; i < p; i++)
            tick(i < p / 2, (i == 0) ? clr_first : 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period_last"},  mon_if.period_last, 0);
        chk({tag, "_period_vld"},   mon_if.period_vld, 0);
        chk({tag, "_edge_cnt_win"}, mon_if.edge_cnt_win, 0);
        chk({tag, "_win_done"},     mon_if.win_done, 0);
        chk({tag, "_locked"},       mon_if.locked, 0);
        chk({tag, "_err_period"},   mon_if.err_period, 0);
        chk({tag, "_err_count"},    mon_if.err_count, 0);
        chk({tag, "_err_stuck"},    mon_if.err_stuck, 0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (mon_if.period_vld) begin
                if (q_per.size() == 0) chk("period_vld_unexpected", 1, 0);
                else                   chk("period_last", mon_if.period_last, q_per.pop_front());
            end
            if (mon_if.win_done) begin
                if (q_win.size() == 0) chk("win_done_unexpected", 1, 0);
                else                   chk("edge_cnt_win", mon_if.edge_cnt_win, q_win.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, clr_tick;
        mon_if.clk_in  = 1'b0;
        mon_if.mon_en  = 1'b1;
        mon_if.clr_err = 1'b0;
        //        per reps lock errp errc errs
        tbl[0] = '{9,  1,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8,  3,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{9,  7,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8,  3,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{9,  7,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8, 10,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{12, 1,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{8,  4,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8,  2,  1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk_all_zero("reset");
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (5) tick(1'b0, 1'b0);

        for (int s = 0; s < 9; s++) begin
            for (int r = 0; r < tbl[s].reps; r++) run_period(tbl[s].per, 1'b0);
            @(negedge sys_clk);
            chk($sformatf("seg%0d_locked", s),     mon_if.locked,     tbl[s].exp_lock);
            chk($sformatf("seg%0d_err_period", s), mon_if.err_period, tbl[s].exp_errp);
            chk($sformatf("seg%0d_err_count", s),  mon_if.err_count,  tbl[s].exp_errc);
            chk($sformatf("seg%0d_err_stuck", s),  mon_if.err_stuck,  tbl[s].exp_errs);
        end

        // Hold clk_in low: err_stuck must appear one cycle after 18 idle cycles.
        r0 = m_last;
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 1'b0);
            @(negedge sys_clk);
            if (n_tick == r0 + STUCK) chk("stuck_early", mon_if.err_stuck, 0);
            if (n_tick == r0 + STUCK + 1) begin
                chk("stuck_set",    mon_if.err_stuck, 1);
                chk("stuck_unlock", mon_if.locked, 0);
            end
        end

        run_period(9, 1'b1);
        repeat (5) run_period(9, 1'b0);
        @(negedge sys_clk);
        chk("relock_locked",     mon_if.locked, 1);
        chk("relock_err_period", mon_if.err_period, 0);
        chk("relock_err_stuck",  mon_if.err_stuck, 0);
        chk("relock_err_count",  mon_if.err_count, 0);

        repeat (50) run_period(4, 1'b0);
        @(negedge sys_clk);
        chk("p4_err_period", mon_if.err_period, 1);
        chk("p4_err_count",  mon_if.err_count, 1);
        chk("p4_locked",     mon_if.locked, 0);

        tick(1'b1, 1'b1);
        clr_tick = n_tick;
        tick(1'b1, 1'b0);
        @(negedge sys_clk);
        chk("clr_vs_set_err_period", mon_if.err_period, 1);
        chk("clr_err_stuck",         mon_if.err_stuck, 0);
        chk("clr_err_count",         mon_if.err_count, (m_win_tick == clr_tick) ? 1 : 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        repeat (12) run_period(8, 1'b0);
        m_en = 1'b0;
        for (int k = 0; k < 96; k++) begin
            tick((k % 8) < 4, 1'b0);
            @(negedge sys_clk);
            if (k > 0) begin
                chk("dis_win_done",   mon_if.win_done, 0);
                chk("dis_period_vld", mon_if.period_vld, 0);
            end
        end
        chk("dis_period_last_kept", mon_if.period_last, m_lastper);
        chk("dis_edge_cnt_kept",    mon_if.edge_cnt_win, m_lastwin);
        chk("dis_locked",           mon_if.locked, 0);
        chk("dis_err_period_kept",  mon_if.err_period, 1);

        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk_all_zero("rst2");
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);

        chk("q_per_drained", q_per.size(), 0);
        chk("q_win_drained", q_win.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/div_period_mon.md
# div_period_mon

Cycle-accurate monitor for the 8/9 mixed-ratio divided clock produced by the fractional divider. It sits directly downstream of the divider in the sys_clk domain, samples the divided clock as an ordinary data signal, and measures each period in sys_clk cycles. It also counts rising edges per fixed window and raises sticky error flags when period, edge count or activity fall outside limits. Bring-up logic and the system CSR bank use it to confirm the divider is locked to its pattern.

## Interface
- WIN, 87: window length in sys_clk cycles (one full divider M_N cycle)
- PER_MIN, 8: minimum legal period, sys_clk cycles
- PER_MAX, 9: maximum legal period, sys_clk cycles
- EXP_EDGES, 10: expected rising edges per window
- EDGE_TOL, 1: allowed absolute deviation from EXP_EDGES
- LOCK_N, 4: consecutive legal periods required for lock
- CNT_W, 8: width of the period and window counters
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- clk_in  in  1  divided clock under test; registered in the sys_clk domain, no synchronizer
- mon_en  in  1  level; 1 = monitor runs
- clr_err  in  1  one-cycle pulse; clears all sticky errors
- period_last  out  CNT_W  most recent measured period
- period_vld  out  1  one-cycle pulse when period_last updates
- edge_cnt_win  out  8  rising edges counted in the last completed window
- win_done  out  1  one-cycle pulse when edge_cnt_win updates
- locked  out  1  LOCK_N consecutive legal periods seen
- err_period  out  1  sticky; a period fell outside [PER_MIN, PER_MAX]
- err_count  out  1  sticky; window edge count deviated by more than EDGE_TOL
- err_stuck  out  1  sticky; no rising edge for 2*PER_MAX cycles

## Operation
- Rise detection: clk_d <= clk_in each cycle; rise = clk_in & ~clk_d. clk_d resets to 0.
- FSM states: IDLE, SYNC, RUN.
  - IDLE: counters are held at 0. mon_en=1 moves the FSM to SYNC.
  - SYNC: waits for the first rise. On that rise, the FSM moves to RUN, period_cnt <= 1, win_cnt <= 1 and win_edges <= 0. No period is reported for the partial period before this rise.
  - RUN: period_cnt increments every cycle and saturates at 2^CNT_W-1.
- Rise in RUN:
  - period_last <= period_cnt, which equals the sys_clk cycles since the previous rise; a period of 8 reports 8.
  - period_vld pulses, period_cnt <= 1, win_edges increments.
- Legality check on each reported period:
  - Legal if PER_MIN <= period <= PER_MAX. A legal period increments lock_run, saturating at LOCK_N.
  - An illegal period sets err_period, clears lock_run and drops locked.
  - locked = (lock_run == LOCK_N).
- Stuck detection: if period_cnt reaches 2*PER_MAX in RUN without a rise, set err_stuck, clear lock_run and move to SYNC.
- Window:
  - win_cnt counts 1..WIN in RUN.
  - On the cycle where win_cnt == WIN: edge_cnt_win <= win_edges (plus 1 if a rise occurs that same cycle), win_done pulses, win_cnt <= 1, win_edges <= 0.
  - If |edge_cnt_win − EXP_EDGES| > EDGE_TOL, set err_count.
- mon_en=0 in any state: return to IDLE next cycle. Counters and lock_run clear. Sticky errors, period_last and edge_cnt_win are retained.
- clr_err clears all three sticky errors. If clr_err coincides with a new error event, the set wins.
- Arithmetic: comparisons are unsigned. win_edges saturates at 255.

## Timing
- Reset values: all outputs 0; FSM in IDLE.
- Rise detection is combinational on registered clk_in and clk_d. All outputs are registered.
- period_vld, period_last and err_period update one cycle after the cycle in which rise is true.
- win_done and edge_cnt_win update one cycle after win_cnt == WIN.
- err_stuck asserts one cycle after period_cnt reaches 2*PER_MAX.
- A reset mid-window aborts the window; no win_done is produced.
- Entering SYNC after a stuck event restarts the window, and the partial window is discarded.

## Structure
- Package div_mon_pkg holds the FSM state enum (IDLE/SYNC/RUN), the default parameter values and the STUCK_LIM = 2*PER_MAX constant function.
- One sub-module, rise_det: a single flop plus AND gate, also reused by other monitors.
- The top level holds the FSM, the period/window counters and the error logic.

## Test plan
- Reset release with mon_en=1 and an ideal 8/9 divider pattern (3×8 then 7×9 per 87 cycles) -> locked=1 after the 4th legal period; edge_cnt_win within 9..11 every window; no errors.
- clk_in with a constant period of 8 -> each period_vld shows period_last=8; locked stays 1.
- Insert one period of 12 -> err_period=1 and locked=0 one cycle after that rise; lock regained after 4 legal periods; err_period stays 1 until clr_err.
- Hold clk_in low after lock -> err_stuck=1 when period_cnt reaches 18; FSM goes to SYNC; resumed toggling re-locks.
- Period-4 clock (period error expected) -> edge_cnt_win ≈ 21 and err_count=1; then clr_err asserted in the same cycle as a further err_period event -> err_period remains 1.
- mon_en dropped mid-window, then sys_rst_n pulsed -> no win_done while disabled; all outputs 0 after reset.
